// File: rtl/shift_serializer.sv
// Parallel-to-serial shifter with valid/ready on both sides, LSB- or MSB-first, variable length.
// Optional even-parity trailer bit when SHIFT_SER_PARITY_EN is defined.
module shift_serializer #(
  parameter int N  = 32,
  parameter int LW = 6
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_dir,
  input  logic [LW-1:0] in_len,
  output logic          sout,
  output logic          sout_valid,
  input  logic          sout_ready,
  output logic          sout_last,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SHIFT_SER_PARITY_EN
    ,
    PAR   = 2'd2
`endif
  } state_e;

  localparam logic [LW-1:0] LEN_MAX = LW'(N);
  localparam logic [N-1:0]  ONES    = '1;

  state_e        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [LW-1:0] count_q, count_d;
  logic          dir_q, dir_d;
  logic          in_ready_q, in_ready_d;
  logic          done_q, done_d;
`ifdef SHIFT_SER_PARITY_EN
  logic          par_q, par_d;
`endif

  logic          accept;
  logic          xfer;
  logic [LW-1:0] len_c;
  logic [LW-1:0] pad;
  logic [N-1:0]  data_m;

  assign accept = in_valid && in_ready_q;
  assign xfer   = sout_valid && sout_ready;

  // Mask off bits above len, and pre-align MSB-first words so bit len-1 sits at N-1.
  always_comb begin
    len_c  = ((in_len == '0) || (in_len > LEN_MAX)) ? LEN_MAX : in_len;
    pad    = LEN_MAX - len_c;
    data_m = in_data & (ONES >> pad);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      count_q    <= '0;
      dir_q      <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef SHIFT_SER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
`ifdef SHIFT_SER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (xfer && (count_q == LW'(1))) begin
`ifdef SHIFT_SER_PARITY_EN
        state_d = PAR;
`else
        state_d = IDLE;
`endif
      end
`ifdef SHIFT_SER_PARITY_EN
      PAR:   if (xfer) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    dir_d   = dir_q;
`ifdef SHIFT_SER_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      shreg_d = in_dir ? (data_m << pad) : data_m;
      count_d = len_c;
      dir_d   = in_dir;
`ifdef SHIFT_SER_PARITY_EN
      par_d   = 1'b0;
`endif
    end else if (xfer && (state_q == SHIFT)) begin
      shreg_d = dir_q ? (shreg_q << 1) : (shreg_q >> 1);
      count_d = count_q - LW'(1);
`ifdef SHIFT_SER_PARITY_EN
      par_d   = par_q ^ sout;
`endif
    end
    // Only the final transfer takes a busy state back to IDLE.
    in_ready_d = (state_d == IDLE);
    done_d     = (state_q != IDLE) && (state_d == IDLE);
  end

  always_comb begin
    busy       = (state_q != IDLE);
    sout_valid = busy;
    sout       = 1'b0;
    sout_last  = 1'b0;
    unique case (state_q)
      SHIFT: begin
        sout = dir_q ? shreg_q[N-1] : shreg_q[0];
`ifndef SHIFT_SER_PARITY_EN
        sout_last = (count_q == LW'(1));
`endif
      end
`ifdef SHIFT_SER_PARITY_EN
      PAR: begin
        sout      = par_q;
        sout_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Scoreboard bench for shift_serializer: expected bits queued at send time, popped on each transfer.
module tb_shift_serializer;
  localparam int N  = 32;
  localparam int LW = 6;
`ifdef SHIFT_SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          in_dir = 1'b0;
  logic [LW-1:0] in_len = '0;
  logic          sout, sout_valid, sout_last, done, busy;
  logic          sout_ready = 1'b1;

  shift_serializer #(.N(N), .LW(LW)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .in_len(in_len),
    .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready),
    .sout_last(sout_last), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_done_cyc = 0;
  int done_cnt = 0;
  int pend_done = 0;
  int xfers = 0;
  int rdy_mode = 0;
  int ph = 0;
  logic [1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: sout_ready = 1'b1;
      1: begin sout_ready = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
      default: sout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic have_prev = 1'b0;
  logic prev_v, prev_r, prev_s, prev_l;
  always @(negedge clk) begin
    logic [1:0] e;
    if (clr) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_v && !prev_r) begin
        check("hold_valid", 32'(sout_valid), 32'd1);
        check("hold_bit",   32'(sout),       32'(prev_s));
        check("hold_last",  32'(sout_last),  32'(prev_l));
      end
      if (done) begin
        check("done_expected", 32'(pend_done != 0), 32'd1);
        if (pend_done > 0) pend_done--;
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (sout_valid && sout_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("bit",  32'(sout),      32'(e[0]));
          check("last", 32'(sout_last), 32'(e[1]));
          if (e[1]) pend_done++;
        end
        xfers++;
      end
      have_prev = 1'b1;
      prev_v = sout_valid; prev_r = sout_ready; prev_s = sout; prev_l = sout_last;
    end
  end

  task automatic send(input logic [N-1:0] d, input logic dir, input logic [LW-1:0] len);
    int L;
    int t;
    logic p;
    L = ((len == 0) || (int'(len) > N)) ? N : int'(len);
    p = 1'b0;
    for (int k = 0; k < L; k++) begin
      int idx;
      idx = dir ? (L - 1 - k) : k;
      p ^= d[idx];
      sb.push_back({(PB == 0) && (k == L - 1), d[idx]});
    end
    if (PB != 0) sb.push_back({1'b1, p});
    in_data = d; in_dir = dir; in_len = len; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 1000) begin @(posedge clk); #1; t++; end
    if (!in_ready) check("accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || sb.size() != 0 || pend_done != 0) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    check("idle_timeout", 32'(t < 2000), 32'd1);
  endtask

  initial begin
    int a2, x0, d0, t;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready),   32'd0);
    check("rst_valid",    32'(sout_valid), 32'd0);
    check("rst_sout",     32'(sout),       32'd0);
    check("rst_last",     32'(sout_last),  32'd0);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_done",     32'(done),       32'd0);
    clr = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    send(32'h0000_00A5, 1'b0, 6'd8);
    check("first_valid", 32'(sout_valid), 32'd1);
    check("first_bit",   32'(sout),       32'd1);
    check("busy_on",     32'(busy),       32'd1);
    check("ready_off",   32'(in_ready),   32'd0);
    wait_idle();
    check("done_latency8", 32'(last_done_cyc - acc_cyc), 32'(8 + PB));

    send(32'h0000_00A5, 1'b1, 6'd0);
    a2 = acc_cyc;
    send(32'h0000_003C, 1'b0, 6'd6);
    check("done_latency32", 32'(last_done_cyc - a2), 32'(32 + PB));
    check("b2b_accept",     32'(acc_cyc - 1),         32'(last_done_cyc));
    wait_idle();

    rdy_mode = 1;
    @(posedge clk); #1;
    x0 = xfers; d0 = done_cnt;
    send(32'h0000_0009, 1'b0, 6'd4);
    wait_idle();
    check("stall_xfers", 32'(xfers - x0),    32'(4 + PB));
    check("stall_done",  32'(done_cnt - d0), 32'd1);
    rdy_mode = 0;
    @(posedge clk); #1;

    x0 = xfers; d0 = done_cnt;
    send(32'h0000_005A, 1'b0, 6'd8);
    t = 0;
    while (xfers - x0 < 3 && t < 100) begin @(posedge clk); #1; t++; end
    check("abort_reach3", 32'(xfers - x0), 32'd3);
    clr = 1'b1;
    #1;
    check("abort_valid", 32'(sout_valid), 32'd0);
    check("abort_sout",  32'(sout),       32'd0);
    check("abort_last",  32'(sout_last),  32'd0);
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_ready", 32'(in_ready),   32'd0);
    check("abort_done",  32'(done),       32'd0);
    sb.delete();
    pend_done = 0;
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    check("ready_after_clr", 32'(in_ready), 32'd1);
    check("no_done_abort",   32'(done_cnt - d0), 32'd0);
    send(32'h0000_00C3, 1'b1, 6'd8);
    wait_idle();
    check("done_after_abort", 32'(done_cnt - d0), 32'd1);

    send(32'hFFFF_FF00, 1'b0, 6'd8);
    send(32'hFFFF_FF5A, 1'b1, 6'd8);
    send(32'hDEAD_BEEF, 1'b0, 6'd40);
    wait_idle();

    rdy_mode = 2;
    for (int w = 0; w < 8; w++)
      send($urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    wait_idle();
    rdy_mode = 0;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
